// File: rtl/fc_mac_neuron.sv
// fc_mac_neuron
// Sequential fixed-point neuron for a fully-connected layer. Each chunk is
// loaded as one weight beat (bias on lane 0, weights on lanes 1..INPUT_SZ)
// followed by one value beat (lanes 0..INPUT_SZ-1). The chunk is multiplied
// and accumulated in a single MAC cycle. After the last chunk the bias is
// added, the sum is saturated to SIZE bits, ReLU is optionally applied, and
// the result is offered on a valid/ready handshake.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   start               begin a neuron (honoured in IDLE only)
//   num_chunks          beats per neuron, captured with start
//   relu_en             clamp negative results to zero, captured with start
//   i_values            (INPUT_SZ+1) lanes of SIZE bits, lane k at [k*SIZE +: SIZE]
//   load_enable         0 = value beat, 1 = bias + weight beat, 2/3 = illegal
//   in_valid, in_ready  input beat handshake
//   o_value, o_valid    result and its valid flag
//   o_ready             consumer accepts result
//   busy                high whenever not IDLE
//   o_err               sticky protocol error, cleared by an accepted start
module fc_mac_neuron #(
  parameter int SIZE       = 16,
  parameter int PRECISION  = 11,
  parameter int INPUT_SZ   = 4,
  parameter int MAX_CHUNKS = 64,
  localparam int CW        = $clog2(MAX_CHUNKS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CW-1:0]                num_chunks,
  input  logic                         relu_en,
  input  logic [(INPUT_SZ+1)*SIZE-1:0] i_values,
  input  logic [1:0]                   load_enable,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [SIZE-1:0]              o_value,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic                         busy,
  output logic                         o_err
);

  localparam int ACC_W = SIZE + $clog2(INPUT_SZ * MAX_CHUNKS) + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (SIZE - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_WAIT = 3'd1,
    V_WAIT = 3'd2,
    MAC    = 3'd3,
    FINISH = 3'd4,
    OUT    = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic signed [SIZE-1:0]  w_q [INPUT_SZ];
  logic signed [SIZE-1:0]  v_q [INPUT_SZ];
  logic signed [SIZE-1:0]  bias_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CW-1:0]           cnt_q;
  logic [CW-1:0]           nch_q;
  logic                    relu_q;
  logic [SIZE-1:0]         o_value_q;
  logic                    o_err_q;

  logic                    beat_fire;
  logic                    w_beat;
  logic                    v_beat;
  logic                    bad_beat;
  logic                    start_go;
  logic [CW-1:0]           cnt_inc;
  logic signed [ACC_W-1:0] mac_sum;
  logic signed [ACC_W-1:0] fin_sum;

  // One lane product: full 2*SIZE product, arithmetic shift (floor), then
  // resized to the accumulator width with sign extension.
  function automatic logic signed [ACC_W-1:0] mac_lane(
    input logic signed [SIZE-1:0] w,
    input logic signed [SIZE-1:0] v
  );
    logic signed [2*SIZE-1:0] prod;
    logic signed [2*SIZE-1:0] shifted;
    prod    = w * v;
    shifted = prod >>> PRECISION;
    return ACC_W'(shifted);
  endfunction

  function automatic logic signed [SIZE-1:0] saturate(
    input logic signed [ACC_W-1:0] s
  );
    if (s > SAT_MAX)      return SAT_MAX[SIZE-1:0];
    else if (s < SAT_MIN) return SAT_MIN[SIZE-1:0];
    else                  return SIZE'(s);
  endfunction

  function automatic logic signed [SIZE-1:0] apply_relu(
    input logic signed [SIZE-1:0] s,
    input logic                   en
  );
    if (en && s < 0) return '0;
    else             return s;
  endfunction

  // Beat classification: a beat of the wrong mode for the current state is
  // consumed but discarded, and only raises the error flag.
  assign start_go  = start && (state_q == IDLE);
  assign beat_fire = in_valid && in_ready;
  assign w_beat    = beat_fire && (state_q == W_WAIT) && (load_enable == 2'd1);
  assign v_beat    = beat_fire && (state_q == V_WAIT) && (load_enable == 2'd0);
  assign bad_beat  = beat_fire && !w_beat && !v_beat;
  assign cnt_inc   = cnt_q + CW'(1);

  always_comb begin
    mac_sum = '0;
    for (int i = 0; i < INPUT_SZ; i++) begin
      mac_sum = mac_sum + mac_lane(w_q[i], v_q[i]);
    end
  end

  assign fin_sum = acc_q + ACC_W'(bias_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_chunks == '0) ? FINISH : W_WAIT;
      W_WAIT:  if (w_beat) state_d = V_WAIT;
      V_WAIT:  if (v_beat) state_d = MAC;
      MAC:     state_d = (cnt_inc < nch_q) ? W_WAIT : FINISH;
      FINISH:  state_d = OUT;
      OUT:     if (o_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    in_ready = (state_q == W_WAIT) || (state_q == V_WAIT);
    busy     = (state_q != IDLE);
    o_valid  = (state_q == OUT);
  end

  assign o_value = o_value_q;
  assign o_err   = o_err_q;

  // Operand capture, accumulation and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < INPUT_SZ; i++) begin
        w_q[i] <= '0;
        v_q[i] <= '0;
      end
      bias_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      nch_q     <= '0;
      relu_q    <= 1'b0;
      o_value_q <= '0;
      o_err_q   <= 1'b0;
    end else begin
      if (start_go) begin
        acc_q   <= '0;
        cnt_q   <= '0;
        bias_q  <= '0;
        nch_q   <= num_chunks;
        relu_q  <= relu_en;
        o_err_q <= 1'b0;
      end
      if (w_beat) begin
        for (int i = 0; i < INPUT_SZ; i++) begin
          w_q[i] <= $signed(i_values[(i+1)*SIZE +: SIZE]);
        end
        // Lane 0 of later weight beats is ignored; bias belongs to chunk 0.
        if (cnt_q == '0) bias_q <= $signed(i_values[0 +: SIZE]);
      end
      if (v_beat) begin
        for (int i = 0; i < INPUT_SZ; i++) begin
          v_q[i] <= $signed(i_values[i*SIZE +: SIZE]);
        end
      end
      if (bad_beat) o_err_q <= 1'b1;
      if (state_q == MAC) begin
        acc_q <= acc_q + mac_sum;
        cnt_q <= cnt_inc;
      end
      if (state_q == FINISH) begin
        o_value_q <= apply_relu(saturate(fin_sum), relu_q);
      end
    end
  end

endmodule
